instruction_queue: RTL and testbench



---
 rtl/instruction_queue.sv | 112 +++++++++++
 tb/tb_instruction_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// Instruction FIFO: packs {opcode, operands} into one word and buffers DEPTH words behind a post-reset warm-up.
// Optional macro IQ_BYPASS_EN adds a same-cycle pass-through from input to output when the queue is empty.
module instruction_queue #(
  parameter  int OPCODE_W      = 8,
  parameter  int OPERAND_W     = 8,
  parameter  int NUM_OPERANDS  = 2,
  parameter  int DEPTH         = 4,
  parameter  int STARTUP_DELAY = 2,
  localparam int INST_W        = OPCODE_W + NUM_OPERANDS*OPERAND_W,
  localparam int CNT_W         = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OPCODE_W-1:0]            in_opcode,
  input  logic [NUM_OPERANDS*OPERAND_W-1:0] in_operands,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INST_W-1:0]              out_inst,
  output logic [CNT_W-1:0]               count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WU_W  = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'((STARTUP_DELAY > 0) ? STARTUP_DELAY - 1 : 0);

  typedef enum logic {WARMUP, RUN} state_t;

  // A zero-length warm-up means the queue comes out of reset already running.
  localparam state_t RESET_STATE = (STARTUP_DELAY == 0) ? RUN : WARMUP;

  state_t            r_state, w_nextState;
  logic [WU_W-1:0]   r_warmCnt, w_nextWarmCnt;
  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rdPtr, r_wrPtr;
  logic [CNT_W-1:0]  r_count;
  logic [INST_W-1:0] r_lastInst;
  logic [INST_W-1:0] w_inWord;
  logic              w_empty, w_inReady, w_bypass, w_push, w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RESET_STATE;
      r_warmCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_warmCnt <= w_nextWarmCnt;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextWarmCnt = r_warmCnt;
    if (r_state == WARMUP) begin
      w_nextWarmCnt = r_warmCnt + WU_W'(1);
      if (r_warmCnt == WU_LAST) w_nextState = RUN;
    end
  end

  assign w_inWord  = {in_opcode, in_operands};
  assign w_empty   = (r_count == '0);
  assign w_inReady = (r_state == RUN) && (r_count < CNT_W'(DEPTH));

`ifdef IQ_BYPASS_EN
  assign w_bypass = w_empty && (r_state == RUN) && !flush && in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word taken by the consumer in the same cycle is never stored.
  assign w_push = in_valid && w_inReady && !(w_bypass && out_ready);
  assign w_pop  = !w_empty && out_ready;

  assign in_ready  = w_inReady;
  assign out_valid = !w_empty || w_bypass;
  assign out_inst  = w_bypass ? w_inWord : (w_empty ? r_lastInst : r_mem[r_rdPtr]);
  assign count     = r_count;

  // Flush wins over any push or pop in the same cycle; storage contents are left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_lastInst <= '0;
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + PTR_W'(1);
        r_lastInst <= r_mem[r_rdPtr];
      end else if (w_bypass && out_ready) begin
        r_lastInst <= w_inWord;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wrPtr] <= w_inWord;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed scoreboard bench for instruction_queue: the driver queues expected words, a negedge monitor checks pops.
module tb_instruction_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [15:0] in_operands;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [23:0] expQ[$];

  instruction_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operands(in_operands),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest word the driver expects.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop actual=%0h required=none", out_inst);
      end else begin
        logic [23:0] expWord;
        expWord = expQ.pop_front();
        checkOutput("pop_order", {8'h0, out_inst}, {8'h0, expWord});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs and records the word the queue should eventually emit.
  task automatic applyStimulus(input bit v, input logic [23:0] w, input bit ordy, input bit fl);
    in_valid    = v;
    in_opcode   = w[23:16];
    in_operands = w[15:0];
    out_ready   = ordy;
    flush       = fl;
    #1;
    if (fl) expQ.delete();
    else if (v && in_ready) expQ.push_back(w);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_opcode = 8'h12; in_operands = 16'h3456;
    #2;
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_in_ready",  {31'h0, in_ready},  32'h0);
    checkOutput("reset_count",     {29'h0, count},     32'h0);
    checkOutput("reset_out_inst",  {8'h0, out_inst},   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Warm-up: two cycles of in_ready low, then the first push.
    checkOutput("warmup_c1", {31'h0, in_ready}, 32'h0);
    tick();
    checkOutput("warmup_c2", {31'h0, in_ready}, 32'h0);
    tick();
    checkOutput("warmup_c3", {31'h0, in_ready}, 32'h1);
    applyStimulus(1'b1, 24'h123456, 1'b0, 1'b0);
    checkOutput("first_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("first_out_inst",  {8'h0, out_inst},   32'h123456);
    checkOutput("first_count",     {29'h0, count},     32'h1);
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("drain1_count", {29'h0, count}, 32'h0);

    // Fill to DEPTH, try a fifth word, then drain in order.
    applyStimulus(1'b1, 24'h01AAAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h02BBBB, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h03CCCC, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h04DDDD, 1'b0, 1'b0);
    checkOutput("full_count",    {29'h0, count},    32'h4);
    checkOutput("full_in_ready", {31'h0, in_ready}, 32'h0);
    applyStimulus(1'b1, 24'h05EEEE, 1'b0, 1'b0);
    checkOutput("full_ignore_count", {29'h0, count}, 32'h4);
    checkOutput("full_head", {8'h0, out_inst}, 32'h01AAAA);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("drained_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("drained_count",     {29'h0, count},     32'h0);
    checkOutput("empty_hold_inst",   {8'h0, out_inst},   32'h04DDDD);

    // Steady stream at occupancy 2 with pointer wrap.
    applyStimulus(1'b1, 24'hA00001, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hA00002, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 24'hB00000 + 24'(i), 1'b1, 1'b0);
      checkOutput("stream_count", {29'h0, count}, 32'h2);
    end
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
    checkOutput("stream_drained", {29'h0, count}, 32'h0);

    // Flush at occupancy 3 discards the concurrent push and pop.
    applyStimulus(1'b1, 24'hC00001, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hC00002, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hC00003, 1'b0, 1'b0);
    checkOutput("preflush_count", {29'h0, count}, 32'h3);
    applyStimulus(1'b1, 24'hC00004, 1'b1, 1'b1);
    checkOutput("flush_count",     {29'h0, count},     32'h0);
    checkOutput("flush_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("flush_in_ready",  {31'h0, in_ready},  32'h1);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
    checkOutput("flush_no_store", {29'h0, count}, 32'h0);

    // Asynchronous reset mid-stream, then warm-up repeats.
    applyStimulus(1'b1, 24'hD00001, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hD00002, 1'b0, 1'b0);
    checkOutput("prereset_count", {29'h0, count}, 32'h2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async_count",     {29'h0, count},     32'h0);
    checkOutput("async_in_ready",  {31'h0, in_ready},  32'h0);
    checkOutput("async_out_inst",  {8'h0, out_inst},   32'h0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    checkOutput("rewarm_c1", {31'h0, in_ready}, 32'h0);
    tick();
    checkOutput("rewarm_c2", {31'h0, in_ready}, 32'h0);
    tick();
    checkOutput("rewarm_c3", {31'h0, in_ready}, 32'h1);
    applyStimulus(1'b1, 24'hE0E1E2, 1'b0, 1'b0);
    checkOutput("rewarm_push_count", {29'h0, count}, 32'h1);
    applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);

`ifdef IQ_BYPASS_EN
    // Same-cycle pass-through on an empty queue.
    in_valid = 1'b1; in_opcode = 8'h7F; in_operands = 16'h0102; out_ready = 1'b1; flush = 1'b0;
    #1;
    checkOutput("bypass_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("bypass_out_inst",  {8'h0, out_inst},   32'h7F0102);
    expQ.push_back(24'h7F0102);
    tick();
    in_valid = 1'b0;
    checkOutput("bypass_count", {29'h0, count}, 32'h0);
    tick();
`endif

    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checkOutput("scoreboard_empty", expQ.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
